// File: rtl/counter_chain_acc.sv
// counter_chain_acc: (1,5)-counter / LOOKAHEAD8 carry-chain bit-heap reducer feeding a
// handshaked PASS/ACC/DUMP accumulator. Define COUNTER_CHAIN_SAT_EN for saturating adds.
module counter_chain_acc #(
   parameter int unsigned LENGTH = 3,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned CNT_W  = 8,
   parameter string       USETNM = "USET0"
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          mode,
   input  logic                clr,
   input  logic [4:0]          C0,
   input  logic                C1,
   input  logic [4*LENGTH-1:0] CL0,
   input  logic [LENGTH-1:0]   CL1,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ACC_W-1:0]    out_data,
   output logic [CNT_W-1:0]    out_cnt,
   output logic                ovf
);
   localparam int unsigned SUM_W = 2*LENGTH + 3;
   localparam int unsigned NCOL  = LENGTH + 1;
   localparam int unsigned NOLA  = (NCOL + 3) / 4;

   typedef enum logic [1:0] {
      MODE_PASS = 2'b00,
      MODE_ACC  = 2'b01,
      MODE_DUMP = 2'b10,
      MODE_RSVD = 2'b11
   } mode_e;

   if (ACC_W < SUM_W) begin : g_acc_w_chk
      $error("counter_chain_acc: ACC_W (%0d) narrower than SUM_W (%0d)", ACC_W, SUM_W);
   end
   if (USETNM == "") begin : g_uset_chk
      $error("counter_chain_acc: USETNM must name a placement set");
   end

   // Column 0 is the tail (C0[3:0], C1); C0[4] enters as the chain carry-in.
   logic [NCOL-1:0][3:0] col_q;
   logic [NCOL-1:0]      col_d;
   logic [NCOL-1:0][2:0] col_val;
   logic [NCOL-1:0]      col_g;
   logic [NCOL-1:0]      col_p;
   logic [NCOL:0]        cy;
   logic [SUM_W-1:0]     sum_s;

   assign col_q = {CL0, C0[3:0]};
   assign col_d = {CL1, C1};
   assign cy[0] = C0[4];

   for (genvar k = 0; k < NCOL; k++) begin : g_col
      assign col_val[k] = 3'(col_q[k][0]) + 3'(col_q[k][1]) + 3'(col_q[k][2])
                        + 3'(col_q[k][3]) + {1'b0, col_d[k], 1'b0};
      assign col_g[k]   = col_val[k][2];
      assign col_p[k]   = (col_val[k] == 3'd3);
      assign sum_s[2*k +: 2] = col_val[k][1:0] + {1'b0, cy[k]};
   end
   assign sum_s[SUM_W-1] = cy[NCOL];

   // Each LOOKAHEAD8 covers four columns; every carry inside depends only on the block carry-in.
   for (genvar b = 0; b < NOLA; b++) begin : g_la8
      localparam int unsigned LO = 4*b;
      localparam int unsigned BW = ((NCOL - LO) < 4) ? (NCOL - LO) : 4;
      logic [BW-1:0] grp_g;
      logic [BW-1:0] grp_p;
      for (genvar j = 0; j < BW; j++) begin : g_pfx
         if (j == 0) begin : g_first
            assign grp_g[j] = col_g[LO];
            assign grp_p[j] = col_p[LO];
         end else begin : g_next
            assign grp_g[j] = col_g[LO+j] | (col_p[LO+j] & grp_g[j-1]);
            assign grp_p[j] = col_p[LO+j] & grp_p[j-1];
         end
         assign cy[LO+j+1] = grp_g[j] | (grp_p[j] & cy[LO]);
      end
   end

   logic             s1_valid;
   logic [SUM_W-1:0] s1_sum;
   mode_e            s1_mode;
   logic             adv;
   logic             accept;

   assign adv      = s1_valid & (~out_valid | out_ready);
   assign in_ready = ~s1_valid | adv;
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_sum   <= '0;
         s1_mode  <= MODE_PASS;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_sum   <= sum_s;
         s1_mode  <= mode_e'(mode);
      end else if (adv) begin
         s1_valid <= 1'b0;
      end
   end

   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] acc_cnt;
   logic             dump_pend;
   logic [ACC_W-1:0] s1_ext;
   logic [ACC_W:0]   add_full;
   logic [ACC_W-1:0] add_res;
   logic             add_c;
   logic [CNT_W-1:0] cnt_next;
   logic             ovf_live;

   always_comb begin
      s1_ext   = ACC_W'(s1_sum);
      add_full = {1'b0, acc} + {1'b0, s1_ext};
      add_c    = add_full[ACC_W];
      add_res  = add_full[ACC_W-1:0];
`ifdef COUNTER_CHAIN_SAT_EN
      if (add_c) add_res = '1;
`endif
      cnt_next = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1);
      // A DUMP's carry is shown on ovf for one cycle only.
      ovf_live = ovf & ~dump_pend;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_cnt   <= '0;
         acc       <= '0;
         acc_cnt   <= '0;
         ovf       <= 1'b0;
         dump_pend <= 1'b0;
      end else begin
         dump_pend <= 1'b0;
         ovf       <= clr ? 1'b0 : ovf_live;
         if (clr) begin
            acc     <= '0;
            acc_cnt <= '0;
         end
         if (out_ready) out_valid <= 1'b0;
         if (adv) begin
            case (s1_mode)
               MODE_ACC: begin
                  if (clr) begin
                     acc     <= s1_ext;
                     acc_cnt <= CNT_W'(1);
                  end else begin
                     acc     <= add_res;
                     acc_cnt <= cnt_next;
                     ovf     <= ovf_live | add_c;
                  end
               end
               MODE_DUMP: begin
                  out_valid <= 1'b1;
                  out_data  <= add_res;
                  out_cnt   <= cnt_next;
                  acc       <= '0;
                  acc_cnt   <= '0;
                  ovf       <= add_c;
                  dump_pend <= 1'b1;
               end
               default: begin
                  out_valid <= 1'b1;
                  out_data  <= s1_ext;
                  out_cnt   <= CNT_W'(1);
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_counter_chain_acc.sv
// Directed self-checking bench for counter_chain_acc: a 32-bit and a 10-bit accumulator
// instance share stimulus so wrap/saturation is observed alongside exact results.
module tb_counter_chain_acc;
   localparam logic [1:0] M_PASS = 2'b00;
   localparam logic [1:0] M_ACC  = 2'b01;
   localparam logic [1:0] M_DUMP = 2'b10;
   localparam logic [1:0] M_RSVD = 2'b11;
`ifdef COUNTER_CHAIN_SAT_EN
   localparam logic [9:0] B_DUMP1     = 10'd1023;
   localparam logic       B_DUMP1_OVF = 1'b1;
`else
   localparam logic [9:0] B_DUMP1     = 10'd510;
   localparam logic       B_DUMP1_OVF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [1:0]  mode;
   logic        clr;
   logic [4:0]  C0;
   logic        C1;
   logic [11:0] CL0;
   logic [2:0]  CL1;
   logic        out_ready;
   logic        in_ready,  in_ready_b;
   logic        out_valid, out_valid_b;
   logic [31:0] out_data;
   logic [9:0]  out_data_b;
   logic [7:0]  out_cnt,   out_cnt_b;
   logic        ovf,       ovf_b;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned last_wait;
   logic [31:0] qa_data[$];
   logic [7:0]  qa_cnt[$];
   logic [9:0]  qb_data[$];
   logic [7:0]  qb_cnt[$];

   always #5 clk = ~clk;

   counter_chain_acc #(.LENGTH(3), .ACC_W(32), .CNT_W(8), .USETNM("USET0")) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .mode(mode), .clr(clr),
      .C0(C0), .C1(C1), .CL0(CL0), .CL1(CL1), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_cnt(out_cnt), .ovf(ovf));

   counter_chain_acc #(.LENGTH(3), .ACC_W(10), .CNT_W(8), .USETNM("USET0")) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .mode(mode), .clr(clr),
      .C0(C0), .C1(C1), .CL0(CL0), .CL1(CL1), .out_valid(out_valid_b), .out_ready(out_ready),
      .out_data(out_data_b), .out_cnt(out_cnt_b), .ovf(ovf_b));

   // Record every result transfer; inputs only change just after posedge, so negedge is stable.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         qa_data.push_back(out_data);
         qa_cnt.push_back(out_cnt);
      end
      if (rst_n && out_valid_b && out_ready) begin
         qb_data.push_back(out_data_b);
         qb_cnt.push_back(out_cnt_b);
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_out(input string tag, input int unsigned idx, input logic [31:0] exp_a,
                            input logic [9:0] exp_b, input logic [7:0] exp_cnt);
      if (idx < qa_data.size() && idx < qb_data.size()) begin
         check({tag, "_a"},     qa_data[idx], exp_a);
         check({tag, "_cnt_a"}, qa_cnt[idx],  exp_cnt);
         check({tag, "_b"},     qb_data[idx], exp_b);
         check({tag, "_cnt_b"}, qb_cnt[idx],  exp_cnt);
      end else begin
         check({tag, "_missing"}, qa_data.size(), idx + 1);
      end
   endtask

   task automatic flush_q();
      qa_data.delete(); qa_cnt.delete(); qb_data.delete(); qb_cnt.delete();
   endtask

   task automatic idle(input int unsigned n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic drive(input logic [1:0] m, input logic [4:0] c0, input logic c1,
                        input logic [11:0] cl0, input logic [2:0] cl1);
      mode = m; C0 = c0; C1 = c1; CL0 = cl0; CL1 = cl1; in_valid = 1'b1;
   endtask

   task automatic send(input logic [1:0] m, input logic [4:0] c0, input logic c1,
                       input logic [11:0] cl0, input logic [2:0] cl1);
      int unsigned waited;
      waited = 0;
      drive(m, c0, c1, cl0, cl1);
      @(negedge clk);
      while (!in_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      last_wait = waited;
      if (!in_ready) check("send_timeout", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_clr();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got %0d vectors, expected completion", n_vec);
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; mode = M_PASS; clr = 1'b0;
      C0 = '0; C1 = 1'b0; CL0 = '0; CL1 = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst_in_ready",   in_ready,   1'b1);
      check("rst_in_ready_b", in_ready_b, 1'b1);
      check("rst_out_valid",  out_valid,  1'b0);
      check("rst_out_data",   out_data,   32'd0);
      check("rst_out_cnt",    out_cnt,    8'd0);
      check("rst_ovf",        ovf,        1'b0);
      check("rst_out_data_b", out_data_b, 10'd0);

      // Latency: S = 5 + 2 = 7, result two edges after the beat is presented.
      send(M_PASS, 5'b11111, 1'b1, 12'h000, 3'b000);
      check("lat_e1_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      check("lat_e2_valid", out_valid, 1'b1);
      check("lat_e2_data",  out_data,  32'd7);
      check("lat_e2_cnt",   out_cnt,   8'd1);
      @(posedge clk); #1;
      check("lat_e3_valid", out_valid, 1'b0);
      idle(1);

      // All-ones heap gives 511; four beats back-to-back, one using reserved mode.
      flush_q();
      send(M_PASS, 5'h1f, 1'b1, 12'hfff, 3'h7); check("b2b_stall0", last_wait, 0);
      send(M_PASS, 5'h1f, 1'b1, 12'hfff, 3'h7); check("b2b_stall1", last_wait, 0);
      send(M_RSVD, 5'h1f, 1'b1, 12'hfff, 3'h7); check("b2b_stall2", last_wait, 0);
      send(M_PASS, 5'h1f, 1'b1, 12'hfff, 3'h7); check("b2b_stall3", last_wait, 0);
      idle(3);
      check("b2b_count", qa_data.size(), 4);
      for (int i = 0; i < 4; i++) check_out("b2b", i, 32'd511, 10'd511, 8'd1);

      // 3 x ACC(511) then DUMP(1): 1534 on the wide instance, wrap/saturate on the 10-bit one.
      pulse_clr();
      flush_q();
      send(M_ACC, 5'h1f, 1'b1, 12'hfff, 3'h7);
      send(M_ACC, 5'h1f, 1'b1, 12'hfff, 3'h7);
      send(M_ACC, 5'h1f, 1'b1, 12'hfff, 3'h7);
      idle(3);
      check("acc_no_output", qa_data.size(), 0);
      check("acc_ovf_a", ovf,   1'b0);
      check("acc_ovf_b", ovf_b, 1'b1);
      send(M_DUMP, 5'b00001, 1'b0, 12'h000, 3'b000);
      @(posedge clk); #1;
      check("dump_ovf_b",  ovf_b, B_DUMP1_OVF);
      check("dump_ovf_a",  ovf,   1'b0);
      @(posedge clk); #1;
      check("dump_ovf_b_clr", ovf_b, 1'b0);
      idle(1);
      check("dump_count", qa_data.size(), 1);
      check_out("dump1", 0, 32'd1534, B_DUMP1, 8'd4);

      flush_q();
      send(M_DUMP, 5'b00000, 1'b0, 12'h000, 3'b000);
      idle(3);
      check_out("dump0_after", 0, 32'd0, 10'd0, 8'd1);

      // Backpressure: out_ready low for 5 cycles while three PASS beats (7, 8, 17) are offered.
      flush_q();
      out_ready = 1'b0;
      drive(M_PASS, 5'b11111, 1'b1, 12'h000, 3'b000);
      @(posedge clk); #1;
      drive(M_PASS, 5'b00000, 1'b0, 12'h000, 3'b001);
      @(posedge clk); #1;
      drive(M_PASS, 5'b00001, 1'b0, 12'h010, 3'b000);
      check("bp_in_ready", in_ready,  1'b0);
      check("bp_valid",    out_valid, 1'b1);
      check("bp_data0",    out_data,  32'd7);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("bp_hold_data",  out_data, 32'd7);
         check("bp_hold_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      idle(4);
      check("bp_count", qa_data.size(), 3);
      check_out("bp0", 0, 32'd7,  10'd7,  8'd1);
      check_out("bp1", 1, 32'd8,  10'd8,  8'd1);
      check_out("bp2", 2, 32'd17, 10'd17, 8'd1);

      // Asynchronous reset mid-stream while a result is stalled and S1 is full.
      send(M_ACC, 5'h1f, 1'b1, 12'hfff, 3'h7);
      out_ready = 1'b0;
      drive(M_PASS, 5'b11111, 1'b1, 12'h000, 3'b000);
      @(posedge clk); #1;
      drive(M_PASS, 5'b00000, 1'b0, 12'h000, 3'b001);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("mrst_pre_valid", out_valid, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("mrst_valid", out_valid, 1'b0);
      check("mrst_data",  out_data,  32'd0);
      check("mrst_cnt",   out_cnt,   8'd0);
      check("mrst_ovf",   ovf,       1'b0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("mrst_in_ready", in_ready, 1'b1);
      flush_q();
      out_ready = 1'b1;
      idle(2);
      check("mrst_no_stray", qa_data.size(), 0);
      send(M_DUMP, 5'b00000, 1'b0, 12'h000, 3'b000);
      idle(3);
      check_out("mrst_acc", 0, 32'd0, 10'd0, 8'd1);

      // Standalone clr between ACC beats: only the post-clear beat survives.
      flush_q();
      send(M_ACC, 5'b11111, 1'b1, 12'h000, 3'b000);
      idle(1);
      pulse_clr();
      send(M_ACC, 5'b00001, 1'b0, 12'h000, 3'b000);
      send(M_DUMP, 5'b00000, 1'b0, 12'h000, 3'b000);
      idle(3);
      check_out("clr_only", 0, 32'd1, 10'd1, 8'd2);

      // clr coinciding with an ACC advance loads acc with that beat's sum.
      flush_q();
      send(M_ACC, 5'h1f, 1'b1, 12'hfff, 3'h7);
      send(M_ACC, 5'b11111, 1'b1, 12'h000, 3'b000);
      pulse_clr();
      send(M_DUMP, 5'b00000, 1'b0, 12'h000, 3'b000);
      idle(3);
      check_out("clr_with_acc", 0, 32'd7, 10'd7, 8'd2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
